// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StWin,
        StLose,
        StBuz,
        StOver
    } game_state_e;

    localparam int unsigned SEL_BACKGROUND = 0;
    localparam logic        SND_LOSE       = 1'b0;
    localparam logic        SND_WIN        = 1'b1;

endpackage

// File: rtl/obj_prio_enc.sv
// Priority encoder over object layers; index 0 has the highest priority.
module obj_prio_enc #(
    parameter int unsigned  NUM_OBJ = 7,
    localparam int unsigned IDXW    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic [NUM_OBJ-1:0] req,
    output logic [IDXW-1:0]    code,
    output logic               valid
);

    // Scan from the lowest priority upwards so the lowest set index wins.
    always_comb begin
        code  = '0;
        valid = 1'b0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (req[i]) begin
                code  = IDXW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Frog game flow: layer select, collision flags, play/win/lose/sound FSM,
// level and lives bookkeeping, lane enable decode.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned        NUM_OBJ     = 7,
    parameter logic [NUM_OBJ-1:0] LETHAL_MASK = 7'b0000111,
    parameter logic [NUM_OBJ-1:0] GOAL_MASK   = 7'b1000000,
    parameter int unsigned        LEVEL_MAX   = 5,
    parameter int unsigned        LIVES_INIT  = 3,
    parameter int unsigned        LANES       = 15,
    parameter int unsigned        STEP        = 3,
    parameter int unsigned        BUZ_CYCLES  = 50_000_000,
    localparam int unsigned       SELW        = $clog2(NUM_OBJ + 2),
    localparam int unsigned       LVLW        = $clog2(LEVEL_MAX + 1),
    localparam int unsigned       LIVW        = $clog2(LIVES_INIT + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [NUM_OBJ-1:0] draw_req,
    input  logic               frog_draw_req,
    input  logic               frame_tick,
    input  logic               start,
    output logic [SELW-1:0]    select_mux,
    output logic               win,
    output logic               lose,
    output logic               game_over,
    output logic               enable_sound,
    output logic               sound_sel,
    output logic [LVLW-1:0]    level,
    output logic [LIVW-1:0]    lives,
    output logic [LANES-1:0]   lane_enable
);

    localparam int unsigned IDXW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int unsigned CNTW = $clog2(BUZ_CYCLES + 1);

    game_state_e     state_q, state_d;
    logic [LVLW-1:0] level_q, level_d;
    logic [LIVW-1:0] lives_q, lives_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            snd_q, snd_d;
    logic            lethal_f_q, lethal_f_d;
    logic            goal_f_q, goal_f_d;

    logic [IDXW-1:0] enc_code;
    logic            enc_valid;
    logic            hit_lethal, hit_goal;
    logic            lethal_now, goal_now;
    int unsigned     lanes_on;

    obj_prio_enc #(
        .NUM_OBJ (NUM_OBJ)
    ) u_prio_enc (
        .req   (draw_req),
        .code  (enc_code),
        .valid (enc_valid)
    );

    assign hit_lethal = (state_q == StPlay) && frog_draw_req && |(draw_req & LETHAL_MASK);
    assign hit_goal   = (state_q == StPlay) && frog_draw_req && |(draw_req & GOAL_MASK);
    // A hit in the same cycle as frame_tick still counts for this frame.
    assign lethal_now = lethal_f_q | hit_lethal;
    assign goal_now   = goal_f_q | hit_goal;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StOver: if (start) state_d = StPlay;
            StPlay: begin
                if (frame_tick) begin
                    if (lethal_now) begin
                        state_d = StLose;
                    end else if (goal_now) begin
                        state_d = StWin;
                    end
                end
            end
            StWin, StLose: state_d = StBuz;
            StBuz: begin
                if (cnt_q <= CNTW'(1)) begin
                    state_d = (lives_q == '0) ? StOver : StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        level_d    = level_q;
        lives_d    = lives_q;
        snd_d      = snd_q;
        cnt_d      = '0;
        lethal_f_d = 1'b0;
        goal_f_d   = 1'b0;
        if (state_q == StPlay && !frame_tick) begin
            lethal_f_d = lethal_f_q | hit_lethal;
            goal_f_d   = goal_f_q | hit_goal;
        end
        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    lives_d = LIVW'(LIVES_INIT);
                    level_d = LVLW'(1);
                end
            end
            StWin: begin
                snd_d   = SND_WIN;
                level_d = (level_q >= LVLW'(LEVEL_MAX)) ? LVLW'(LEVEL_MAX) : level_q + LVLW'(1);
                cnt_d   = CNTW'(BUZ_CYCLES);
            end
            StLose: begin
                snd_d   = SND_LOSE;
                level_d = (level_q <= LVLW'(1)) ? LVLW'(1) : level_q - LVLW'(1);
                lives_d = (lives_q == '0) ? '0 : lives_q - LIVW'(1);
                cnt_d   = CNTW'(BUZ_CYCLES);
            end
            StBuz: cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNTW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            level_q    <= LVLW'(1);
            lives_q    <= '0;
            cnt_q      <= '0;
            snd_q      <= SND_LOSE;
            lethal_f_q <= 1'b0;
            goal_f_q   <= 1'b0;
        end else begin
            level_q    <= level_d;
            lives_q    <= lives_d;
            cnt_q      <= cnt_d;
            snd_q      <= snd_d;
            lethal_f_q <= lethal_f_d;
            goal_f_q   <= goal_f_d;
        end
    end

    always_comb begin
        win          = (state_q == StWin);
        lose         = (state_q == StLose);
        enable_sound = (state_q == StBuz);
        game_over    = (state_q == StOver);
        sound_sel    = snd_q;
        level        = level_q;
        lives        = lives_q;

        if (enc_valid) begin
            select_mux = SELW'(enc_code) + SELW'(1);
        end else if (frog_draw_req) begin
            select_mux = SELW'(NUM_OBJ + 1);
        end else begin
            select_mux = SELW'(SEL_BACKGROUND);
        end

        lanes_on = 32'(level_q) * STEP;
        if (lanes_on > LANES) lanes_on = LANES;
        lane_enable = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_enable[i] = (i < lanes_on);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl: a frame-level game model feeds a
// scoreboard that an independent monitor drains from the DUT outputs.
module tb_game_flow_ctrl;

    localparam int NUM_OBJ    = 7;
    localparam int BUZ        = 5;
    localparam int LEVEL_MAX  = 5;
    localparam int LIVES_INIT = 3;
    localparam int LANES      = 15;
    localparam int STEP       = 3;
    localparam logic [6:0] LETHAL = 7'b0000111;
    localparam logic [6:0] GOAL   = 7'b1000000;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [6:0]  draw_req = '0;
    logic        frog_draw_req = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  select_mux;
    logic        win, lose, game_over, enable_sound, sound_sel;
    logic [2:0]  level;
    logic [1:0]  lives;
    logic [14:0] lane_enable;

    game_flow_ctrl #(
        .BUZ_CYCLES (BUZ)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .draw_req      (draw_req),
        .frog_draw_req (frog_draw_req),
        .frame_tick    (frame_tick),
        .start         (start),
        .select_mux    (select_mux),
        .win           (win),
        .lose          (lose),
        .game_over     (game_over),
        .enable_sound  (enable_sound),
        .sound_sel     (sound_sel),
        .level         (level),
        .lives         (lives),
        .lane_enable   (lane_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_win;
        int lives;
        int level;
        bit over;
    } ev_t;

    typedef enum {MWait, MPlay, MBusy} mode_e;

    ev_t   ev_q[$];
    int    mux_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    mon_phase = 0;

    mode_e mode = MWait;
    int    m_lives = 0;
    int    m_level = 1;
    int    busy_left = 0;
    bit    acc_l = 1'b0;
    bit    acc_g = 1'b0;

    function automatic int ref_sel(input logic [6:0] dr, input logic fr);
        for (int k = 0; k < NUM_OBJ; k++) begin
            if (dr[k]) return k + 1;
        end
        return fr ? NUM_OBJ + 1 : 0;
    endfunction

    function automatic logic [14:0] ref_lanes(input int lvl);
        int n;
        logic [14:0] v;
        n = lvl * STEP;
        if (n > LANES) n = LANES;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game-level model: frames accumulate hits, a tick resolves the frame, then the
    // controller is deaf for the outcome cycle plus the sound duration.
    task automatic model_step(input logic [6:0] dr, input logic fr, input logic tk,
                              input logic st);
        ev_t e;
        case (mode)
            MPlay: begin
                if (fr && ((dr & LETHAL) != 0)) acc_l = 1'b1;
                if (fr && ((dr & GOAL) != 0)) acc_g = 1'b1;
                if (tk) begin
                    if (acc_l || acc_g) begin
                        e.is_win = !acc_l;
                        if (acc_l) begin
                            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                            m_level = (m_level > 1) ? m_level - 1 : 1;
                        end else begin
                            m_level = (m_level < LEVEL_MAX) ? m_level + 1 : LEVEL_MAX;
                        end
                        e.lives = m_lives;
                        e.level = m_level;
                        e.over  = (m_lives == 0);
                        ev_q.push_back(e);
                        mode      = MBusy;
                        busy_left = 1 + BUZ;
                    end
                    acc_l = 1'b0;
                    acc_g = 1'b0;
                end
            end
            MBusy: begin
                busy_left--;
                if (busy_left == 0) mode = (m_lives == 0) ? MWait : MPlay;
            end
            default: begin
                if (st) begin
                    m_lives = LIVES_INIT;
                    m_level = 1;
                    mode    = MPlay;
                end
            end
        endcase
    endtask

    task automatic drive_cycle(input logic [6:0] dr, input logic fr, input logic tk,
                               input logic st);
        @(posedge clk);
        #1;
        draw_req      = dr;
        frog_draw_req = fr;
        frame_tick    = tk;
        start         = st;
        mux_q.push_back(ref_sel(dr, fr));
        model_step(dr, fr, tk, st);
    endtask

    task automatic drive_rand();
        logic [6:0] dr;
        for (int k = 0; k < NUM_OBJ; k++) dr[k] = ($urandom_range(0, 4) == 0);
        drive_cycle(dr, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0));
    endtask

    task automatic garbage(input int n);
        for (int i = 0; i < n; i++) drive_rand();
    endtask

    initial begin : monitor
        ev_t cur;
        int  snd;
        snd = 0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                mon_phase = 0;
            end else begin
                if (mux_q.size() > 0) check("select_mux", 32'(select_mux), 32'(mux_q.pop_front()));
                case (mon_phase)
                    0: begin
                        check("sound_outside_buz", 32'(enable_sound), 32'(0));
                        if (win || lose) begin
                            if (ev_q.size() == 0) begin
                                check("unexpected_outcome", 32'({win, lose}), 32'(0));
                            end else begin
                                cur = ev_q.pop_front();
                                check("win_pulse", 32'(win), 32'(cur.is_win));
                                check("lose_pulse", 32'(lose), 32'(!cur.is_win));
                                mon_phase = 1;
                            end
                        end
                    end
                    1: begin
                        check("lives", 32'(lives), 32'(cur.lives));
                        check("level", 32'(level), 32'(cur.level));
                        check("lane_enable", 32'(lane_enable), 32'(ref_lanes(cur.level)));
                        check("sound_sel", 32'(sound_sel), 32'(cur.is_win));
                        check("sound_start", 32'(enable_sound), 32'(1));
                        snd = 1;
                        mon_phase = 2;
                    end
                    default: begin
                        if (enable_sound) begin
                            snd++;
                            if (snd > BUZ + 4) begin
                                check("sound_runaway", 32'(snd), 32'(BUZ));
                                mon_phase = 0;
                            end
                        end else begin
                            check("sound_cycles", 32'(snd), 32'(BUZ));
                            check("game_over", 32'(game_over), 32'(cur.over));
                            mon_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : stim
        #1 resetN = 1'b0;
        #1;
        check("rst_win", 32'(win), 32'(0));
        check("rst_lose", 32'(lose), 32'(0));
        check("rst_sound", 32'(enable_sound), 32'(0));
        check("rst_over", 32'(game_over), 32'(0));
        check("rst_level", 32'(level), 32'(1));
        check("rst_lives", 32'(lives), 32'(0));
        check("rst_lanes", 32'(lane_enable), 32'(15'h0007));
        check("rst_sound_sel", 32'(sound_sel), 32'(0));
        check("rst_select", 32'(select_mux), 32'(0));
        @(negedge clk);
        resetN = 1'b1;

        // Select codes while idle, then first game.
        drive_cycle(7'b0000110, 1'b1, 1'b0, 1'b0);
        drive_cycle(7'b0000000, 1'b1, 1'b0, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b1);

        drive_cycle(7'b0000010, 1'b1, 1'b1, 1'b0);
        garbage(1 + BUZ);
        drive_cycle(7'b1000000, 1'b1, 1'b1, 1'b0);
        garbage(1 + BUZ);

        // Goal and lethal hits in the same frame.
        drive_cycle(7'b1000000, 1'b1, 1'b0, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b1);
        drive_cycle(7'b0000001, 1'b1, 1'b0, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b1, 1'b0);
        garbage(1 + BUZ);

        for (int i = 0; i < 1500; i++) drive_rand();

        // Lose until game over, then restart.
        for (int k = 0; k < 100 && mode != MWait; k++) begin
            if (mode == MPlay) drive_cycle(7'b0000100, 1'b1, 1'b1, 1'b0);
            else drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b0);
        end
        drive_cycle(7'b0001000, 1'b1, 1'b1, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b1);

        for (int w = 0; w < 6; w++) begin
            drive_cycle(7'b1000000, 1'b1, 1'b1, 1'b0);
            garbage(1 + BUZ);
        end

        // Reset during the second sound cycle.
        drive_cycle(7'b1000000, 1'b1, 1'b1, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 resetN = 1'b0;
        mode = MWait; m_lives = 0; m_level = 1; busy_left = 0; acc_l = 1'b0; acc_g = 1'b0;
        #1;
        check("midbuz_sound", 32'(enable_sound), 32'(0));
        check("midbuz_win", 32'(win), 32'(0));
        check("midbuz_over", 32'(game_over), 32'(0));
        check("midbuz_level", 32'(level), 32'(1));
        check("midbuz_lives", 32'(lives), 32'(0));
        check("midbuz_lanes", 32'(lane_enable), 32'(15'h0007));
        @(negedge clk);
        #2 resetN = 1'b1;

        drive_cycle(7'b0000000, 1'b0, 1'b1, 1'b0);
        drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b1);
        drive_cycle(7'b0000001, 1'b1, 1'b1, 1'b0);
        garbage(1 + BUZ);
        for (int i = 0; i < 4; i++) drive_cycle(7'b0000000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("events_drained", 32'(ev_q.size()), 32'(0));
        check("monitor_idle", 32'(mon_phase), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
